// File: rtl/run_ctrl.sv
// run_ctrl -- run scheduler for the phase-extraction pipeline.
//
// Lives in the 40 MHz reference-clock domain. A free-running period counter
// (held at zero while enable is low) produces one tick every TICKS cycles.
// Each tick either launches a new run (one-cycle start pulse to the input
// buffer) or, if the previous run is still in flight, is counted as an
// overrun. A run ends when the end-of-run pulse (done) returns from peak
// detection, or, in watchdog builds, when it has been busy too long.
//
// Handshake: start and done are single-cycle pulses, not a valid/ready pair.
// start is issued only from IDLE or together with the done that closes the
// previous run. done is honoured only while busy; a done seen in IDLE is
// dropped without effect.
//
// Build option: define RUN_CTRL_WATCHDOG_EN to build the watchdog counter and
// abort path. Without it, BUSY exits only on done or reset, and timeout is 0.
//
// Ports:
//   clk          40 MHz reference clock
//   reset_n      asynchronous active-low reset
//   enable       level; new runs are scheduled only while high
//   clear        synchronous pulse; zeroes run_cnt, overrun_cnt, timeout
//   done         end-of-run pulse from peak detection
//   start        one-cycle run-start pulse
//   busy         run in flight
//   run_cnt      completed runs, wraps
//   overrun_cnt  ticks lost while busy, saturates at all-ones
//   timeout      sticky: a run was aborted by the watchdog
//   fsm_state    debug view of the FSM (0 = IDLE, 1 = BUSY)
module run_ctrl #(
  parameter int TICKS   = 400000,
  parameter int TIMEOUT = 300000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             done,
  output logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic             timeout,
  output logic             fsm_state
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          start_nxt;
  logic          run_inc;
  logic          ovr_inc;
  logic          to_set;
  logic          abort;

  // Period counter. Holding it at zero while disabled means a rising enable
  // always restarts a full period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == CNT_LAST);

`ifdef RUN_CTRL_WATCHDOG_EN
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0] wd;

  // Age of the current run: zero in the cycle start is high, +1 per BUSY
  // cycle. Parked at zero whenever the FSM is (or is about to be) idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd <= '0;
    end else if (start_nxt || (state_nxt != S_BUSY)) begin
      wd <= '0;
    end else begin
      wd <= wd + 1'b1;
    end
  end

  assign abort = (state == S_BUSY) && (wd == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout <= 1'b0;
    end else if (clear) begin
      timeout <= 1'b0;
    end else if (to_set) begin
      timeout <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign abort      = 1'b0;
  assign timeout    = 1'b0;
  assign unused_cfg = to_set | (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      start <= 1'b0;
    end else begin
      state <= state_nxt;
      start <= start_nxt;
    end
  end

  // done takes priority over a same-cycle watchdog expiry. A tick while
  // busy with no done is a lost period (overrun); when it coincides with an
  // expiry the run is still aborted and the tick is still counted as lost.
  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    run_inc   = 1'b0;
    ovr_inc   = 1'b0;
    to_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick) begin
          state_nxt = S_BUSY;
          start_nxt = 1'b1;
        end
      end
      S_BUSY: begin
        if (done) begin
          run_inc = 1'b1;
          if (tick) begin
            start_nxt = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          if (tick) begin
            ovr_inc = 1'b1;
          end
          if (abort) begin
            state_nxt = S_IDLE;
            to_set    = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // clear beats any same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt     <= '0;
      overrun_cnt <= '0;
    end else if (clear) begin
      run_cnt     <= '0;
      overrun_cnt <= '0;
    end else begin
      if (run_inc) begin
        run_cnt <= run_cnt + 1'b1;
      end
      if (ovr_inc && (overrun_cnt != '1)) begin
        overrun_cnt <= overrun_cnt + 1'b1;
      end
    end
  end

  assign busy      = (state == S_BUSY);
  assign fsm_state = (state == S_BUSY);

endmodule

// File: tb/tb_run_ctrl.sv
`timescale 1ns/1ps
module tb_run_ctrl;

  localparam int TICKS   = 16;
  localparam int TIMEOUT = 12;
  localparam int CNT_W   = 4;
`ifdef RUN_CTRL_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable  = 1'b0;
  logic             clear   = 1'b0;
  logic             done    = 1'b0;
  logic             start;
  logic             busy;
  logic             timeout;
  logic             fsm_state;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] overrun_cnt;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  run_ctrl #(.TICKS(TICKS), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .done        (done),
    .start       (start),
    .busy        (busy),
    .run_cnt     (run_cnt),
    .overrun_cnt (overrun_cnt),
    .timeout     (timeout),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "global time limit");
  end

  // ---------------- reference model ----------------
  // Works in absolute cycle numbers: a tick is every TICKS-th cycle counted
  // from the cycle enable was first seen high, and a run's age is the
  // distance from the cycle its start was visible.
  typedef struct packed {
    bit nb;
    bit ns;
    bit ri;
    bit oi;
    bit ts;
  } step_t;

  function automatic step_t step_rules(input bit busy_now, input bit tk,
                                       input bit dn, input bit expire);
    step_t r;
    r    = '0;
    r.nb = busy_now;
    if (!busy_now) begin
      if (tk) begin r.nb = 1'b1; r.ns = 1'b1; end
    end else if (dn) begin
      r.ri = 1'b1;
      if (tk) r.ns = 1'b1;
      else    r.nb = 1'b0;
    end else begin
      if (tk) r.oi = 1'b1;
      if (expire) begin r.nb = 1'b0; r.ts = 1'b1; end
    end
    return r;
  endfunction

  logic             m_busy, m_start, m_to, en_prev;
  logic [CNT_W-1:0] m_run, m_ovr;
  int               cyc, en_t0, st_t, t0_now;
  logic             m_tick, m_expire;
  step_t            s;

  assign t0_now   = (enable && !en_prev) ? cyc : en_t0;
  assign m_tick   = enable && (((cyc - t0_now) % TICKS) == TICKS - 1);
  assign m_expire = WD && m_busy && ((cyc - st_t) == TIMEOUT - 1);
  assign s        = step_rules(m_busy, m_tick, done, m_expire);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_start <= 1'b0; m_to <= 1'b0; en_prev <= 1'b0;
      m_run  <= '0;   m_ovr   <= '0;
      cyc    <= 0;    en_t0   <= 0;    st_t <= 0;
    end else begin
      cyc     <= cyc + 1;
      en_prev <= enable;
      en_t0   <= t0_now;
      m_busy  <= s.nb;
      m_start <= s.ns;
      if (s.ns) st_t <= cyc + 1;
      if (clear) begin
        m_run <= '0; m_ovr <= '0; m_to <= 1'b0;
      end else begin
        if (s.ri) m_run <= m_run + 1'b1;
        if (s.oi && (m_ovr != '1)) m_ovr <= m_ovr + 1'b1;
        if (s.ts) m_to <= 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; done = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_start(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (start === 1'b1) seen = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({start, busy, run_cnt, overrun_cnt, timeout, fsm_state} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %b want all zero",
                      {start, busy, run_cnt, overrun_cnt, timeout, fsm_state});
    end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    total++; if ({start, busy} !== 2'b00) begin
      bad++; $display("FAIL reset_disabled_idle: got start/busy=%b want 00", {start, busy});
    end
  endtask

  task automatic test_periodic();
    int  done_at;
    logic exp_start;
    do_reset();
    enable  = 1'b1;
    done_at = -1;
    exp_q   = {16'd16, 16'd32, 16'd48};
    for (int k = 1; k <= 56; k++) begin
      @(negedge clk);
      done      = 1'b0;
      exp_start = (exp_q.size() > 0) && (exp_q[0] == 16'(k));
      total++; if (start !== exp_start) begin
        bad++; $display("FAIL periodic_start: cycle %0d got %b want %b", k, start, exp_start);
      end
      if (exp_start) begin
        void'(exp_q.pop_front());
        done_at = k + 5;
      end
      total++; if (busy !== m_busy) begin
        bad++; $display("FAIL periodic_busy: cycle %0d got %b want %b", k, busy, m_busy);
      end
      if (k == done_at) done = 1'b1;
    end
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL periodic_missing: got %0d starts left want 0", exp_q.size());
    end
    total++; if (run_cnt !== 4'd3) begin
      bad++; $display("FAIL periodic_run_cnt: got %0d want 3", run_cnt);
    end
    total++; if ({overrun_cnt, timeout} !== 5'd0) begin
      bad++; $display("FAIL periodic_ovr_to: got %0d/%b want 0/0", overrun_cnt, timeout);
    end
  endtask

  task automatic test_watchdog();
    bit seen;
    do_reset();
    enable = 1'b1;
    wait_start(40, seen);
    total++; if (!seen) begin bad++; $display("FAIL wd_first_start: no start within 40 cycles"); end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      total++; if ({busy, timeout, overrun_cnt} !== {m_busy, m_to, m_ovr}) begin
        bad++; $display("FAIL wd_model: cycle %0d got %b want %b", k,
                        {busy, timeout, overrun_cnt}, {m_busy, m_to, m_ovr});
      end
`ifdef RUN_CTRL_WATCHDOG_EN
      if (k == 11) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wd_busy_before: got %b want 1", busy); end
      end
      if (k == 12) begin
        total++; if ({busy, timeout} !== 2'b01) begin
          bad++; $display("FAIL wd_abort: got busy/timeout=%b want 01", {busy, timeout});
        end
      end
      if (k == 16) begin
        total++; if (start !== 1'b1) begin bad++; $display("FAIL wd_next_start: got %b want 1", start); end
      end
`else
      if (k == 40) begin
        total++; if ({busy, overrun_cnt} !== {1'b1, 4'd2}) begin
          bad++; $display("FAIL nowd_overrun: got busy=%b ovr=%0d want 1/2", busy, overrun_cnt);
        end
      end
`endif
    end
    total++; if (run_cnt !== 4'd0) begin bad++; $display("FAIL wd_run_cnt: got %0d want 0", run_cnt); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    do_reset();
    enable = 1'b1;
    wait_start(40, seen);
    total++; if (!seen) begin bad++; $display("FAIL b2b_first_start: no start within 40 cycles"); end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      done = (k == 15);
      if (k == 16) begin
        total++; if (start !== 1'b1) begin bad++; $display("FAIL b2b_start: got %b want 1", start); end
`ifdef RUN_CTRL_WATCHDOG_EN
        total++; if (run_cnt !== 4'd0) begin bad++; $display("FAIL b2b_wd_run_cnt: got %0d want 0", run_cnt); end
`else
        total++; if ({run_cnt, overrun_cnt} !== {4'd1, 4'd0}) begin
          bad++; $display("FAIL b2b_counts: got run=%0d ovr=%0d want 1/0", run_cnt, overrun_cnt);
        end
`endif
      end
`ifndef RUN_CTRL_WATCHDOG_EN
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: cycle %0d got %b want 1", k, busy); end
`endif
    end
    done = 1'b0;
  endtask

  task automatic test_saturate_wrap();
    bit seen;
    int done_at;
    do_reset();
    enable = 1'b1;
    wait_start(40, seen);
    total++; if (!seen) begin bad++; $display("FAIL sat_first_start: no start within 40 cycles"); end
    repeat (20 * TICKS) @(negedge clk);
`ifdef RUN_CTRL_WATCHDOG_EN
    total++; if (overrun_cnt !== 4'd0) begin bad++; $display("FAIL sat_wd_ovr: got %0d want 0", overrun_cnt); end
`else
    total++; if (overrun_cnt !== 4'hF) begin bad++; $display("FAIL sat_ovr: got %0d want 15", overrun_cnt); end
`endif
    total++; if (overrun_cnt !== m_ovr) begin
      bad++; $display("FAIL sat_ovr_model: got %0d want %0d", overrun_cnt, m_ovr);
    end
    // 17 completed runs wrap a 4-bit counter to 1.
    do_reset();
    enable  = 1'b1;
    done_at = -1;
    for (int k = 1; k <= 17 * TICKS + 8; k++) begin
      @(negedge clk);
      done = 1'b0;
      if (start) done_at = k + 5;
      if (k == done_at) done = 1'b1;
    end
    total++; if (run_cnt !== 4'd1) begin bad++; $display("FAIL wrap_run_cnt: got %0d want 1", run_cnt); end
    wait_start(40, seen);
    total++; if (!seen) begin bad++; $display("FAIL clr_start: no start within 40 cycles"); end
    repeat (5) @(negedge clk);
    done = 1'b1; clear = 1'b1;
    @(negedge clk);
    done = 1'b0; clear = 1'b0;
    total++; if ({run_cnt, overrun_cnt, timeout, busy} !== 10'd0) begin
      bad++; $display("FAIL clear_wins: got run=%0d ovr=%0d to=%b busy=%b want 0/0/0/0",
                      run_cnt, overrun_cnt, timeout, busy);
    end
  endtask

  task automatic test_enable_drop();
    bit seen;
    do_reset();
    enable = 1'b1;
    wait_start(40, seen);
    total++; if (!seen) begin bad++; $display("FAIL endrop_first_start: no start within 40 cycles"); end
    for (int k = 1; k <= 106; k++) begin
      @(negedge clk);
      done = 1'b0;
      if (k == 3) enable = 1'b0;
      if (k == 6) done = 1'b1;
      if (k >= 7) begin
        total++; if ({start, busy} !== 2'b00) begin
          bad++; $display("FAIL endrop_quiet: cycle %0d got start/busy=%b want 00", k, {start, busy});
        end
      end
    end
    total++; if (run_cnt !== 4'd1) begin bad++; $display("FAIL endrop_run_cnt: got %0d want 1", run_cnt); end
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      total++; if (start !== (k == 16)) begin
        bad++; $display("FAIL reenable_start: cycle %0d got %b want %b", k, start, (k == 16));
      end
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    do_reset();
    enable = 1'b1;
    wait_start(40, seen);
    total++; if (!seen) begin bad++; $display("FAIL ar_first_start: no start within 40 cycles"); end
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      done = (k == 5);
    end
    total++; if ({busy, run_cnt} !== {1'b1, 4'd1}) begin
      bad++; $display("FAIL ar_pre: got busy=%b run=%0d want 1/1", busy, run_cnt);
    end
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    total++; if ({start, busy, run_cnt, overrun_cnt, timeout} !== '0) begin
      bad++; $display("FAIL ar_immediate: got %b want all zero", {start, busy, run_cnt, overrun_cnt, timeout});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({busy, run_cnt} !== 5'd0) begin
      bad++; $display("FAIL ar_done_ignored: got busy=%b run=%0d want 0/0", busy, run_cnt);
    end
  endtask

  task automatic test_random();
    int done_odds;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      total++; if ({start, busy, run_cnt, overrun_cnt, timeout, fsm_state} !==
                   {m_start, m_busy, m_run, m_ovr, m_to, m_busy}) begin
        bad++; $display("FAIL random_model: cycle %0d got %b want %b", k,
                        {start, busy, run_cnt, overrun_cnt, timeout, fsm_state},
                        {m_start, m_busy, m_run, m_ovr, m_to, m_busy});
      end
      done_odds = (k < 750) ? 5 : 40;
      done  = ($urandom_range(0, done_odds) == 0);
      clear = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 150) == 0) enable = ~enable;
    end
    done = 1'b0; clear = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_periodic();
    test_watchdog();
    test_back_to_back();
    test_saturate_wrap();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run scheduler for the phase-extraction pipeline. Lives in the reference-clock domain and issues the periodic one-cycle `start` pulse to the input buffer. Tracks each run until the end-of-run pulse returns from peak detection. Counts completed and overrun runs, and flags runs that never complete.

## Interface
Parameters:
- TICKS, 400000, clock cycles per run period (40 MHz / 100 Hz); must be ≥ 4
- TIMEOUT, 300000, max cycles a run may stay busy before abort (watchdog builds only); must be ≥ 2
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  40 MHz reference clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  level; new runs are scheduled only while high
- clear  in  1  synchronous pulse; zeroes run_cnt, overrun_cnt, timeout
- done  in  1  end-of-run pulse (peak-detect valid && eop, already in clk domain)
- start  out  1  one-cycle run-start pulse to input buffer
- busy  out  1  run in flight
- run_cnt  out  CNT_W  completed runs, wraps modulo 2^CNT_W
- overrun_cnt  out  CNT_W  period ticks lost while busy, saturates at all-ones
- timeout  out  1  sticky: a run was aborted by the watchdog

## Operation
- Period counter `cnt`, width $clog2(TICKS), counts 0..TICKS-1 and wraps while enable=1. It is held at 0 while enable=0. `tick` = enable && cnt==TICKS-1.
- FSM states: IDLE, BUSY.
  - IDLE: on tick → BUSY, start=1 for the next cycle. done is ignored.
  - BUSY, done=1: run_cnt+1. If tick in the same cycle, stay in BUSY and pulse start again (back-to-back run, no overrun). Otherwise → IDLE.
  - BUSY, tick without done: overrun_cnt+1 (saturating), stay in BUSY, no start.
  - BUSY, watchdog expiry without done: → IDLE, timeout←1, run_cnt unchanged.
- Watchdog (RUN_CTRL_WATCHDOG_EN builds only): counter cleared on each start and increments every BUSY cycle. It expires when it reaches TIMEOUT-1. If done arrives in the expiry cycle, done wins.
- enable falling mid-run: the current run finishes normally or by watchdog, and no further start is issued. enable rising restarts the period at cnt=0.
- clear has priority over any same-cycle increment or timeout set. clear does not affect the FSM or cnt.
- Reset (reset_n=0, any time, asynchronous):
  - cnt=0, state=IDLE, start=0, busy=0, run_cnt=0, overrun_cnt=0, timeout=0, watchdog=0.
  - An in-flight run is abandoned. A later done is ignored in IDLE.

## Timing
- All outputs are registered.
- start is high exactly one cycle: the cycle after the tick cycle.
- busy rises together with start and falls the cycle after done or watchdog expiry is sampled.
- run_cnt and overrun_cnt update the cycle after the triggering event.
- First start after enable rises (cnt at 0): enable high at cycle 0 → tick at cycle TICKS-1 → start at cycle TICKS. Subsequent starts come every TICKS cycles.
- Watchdog expiry occurs TIMEOUT cycles after start is high.

## Configuration
- Macro RUN_CTRL_WATCHDOG_EN.
  - Defined: the watchdog counter and abort path are built as described.
  - Undefined: no watchdog logic. BUSY exits only on done or reset, the timeout output is tied 0, and the TIMEOUT parameter is unused.

## Test plan
All scenarios use TICKS=16, TIMEOUT=12, CNT_W=4.
- Reset, then enable=1, then done 5 cycles after each start → start every 16 cycles, first at cycle 16. After 3 periods, run_cnt=3, overrun_cnt=0, timeout=0.
- done withheld for 40 cycles (watchdog build) → busy falls 12 cycles after start, timeout=1. The next start follows on the next tick, and run_cnt is unchanged. Same stimulus without the macro → busy stays high and overrun_cnt=2 after 2 ticks.
- done asserted in the same cycle as tick → start pulses the next cycle, busy stays 1, run_cnt+1, overrun_cnt unchanged.
- Force 20 overruns → overrun_cnt saturates at 15. Complete 17 runs → run_cnt wraps to 1. Pulse clear together with a done → run_cnt=0.
- enable dropped 3 cycles after start, done at +6 → busy falls and no further start for 100 cycles. Re-enable → start 16 cycles later.
- reset_n pulsed low mid-BUSY, asynchronously between edges → all outputs 0 immediately. A done 2 cycles after release is ignored and run_cnt stays 0.
